// File: rtl/rr_arb_8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter.
package rr_arb_8_pkg;

    localparam int unsigned NUM_REQ = 8;
    localparam int unsigned SEL_W   = 3;
    localparam int unsigned CNT_W   = 8;

    // Arbiter FSM state encoding.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // One-hot vector with bit idx set.
    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_REQ-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/rr_arb_8_mux_8.sv
// 8:1 data multiplexer, N bits per input; input k lives on data_i[k*N +: N].
module mux_8 #(
    parameter int unsigned N = 8
) (
    input  logic [8*N-1:0] data_i,
    input  logic [2:0]     sel_i,
    output logic [N-1:0]   data_o
);

    // Pure combinational select.
    always_comb begin
        data_o = '0;
        unique case (sel_i)
            3'd0: data_o = data_i[0*N +: N];
            3'd1: data_o = data_i[1*N +: N];
            3'd2: data_o = data_i[2*N +: N];
            3'd3: data_o = data_i[3*N +: N];
            3'd4: data_o = data_i[4*N +: N];
            3'd5: data_o = data_i[5*N +: N];
            3'd6: data_o = data_i[6*N +: N];
            3'd7: data_o = data_i[7*N +: N];
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/rr_arb_8.sv
// Round-robin arbiter sharing one N-bit datapath among 8 requesters, with grant
// holding and an optional burst limit (MAX_BURST = 0 means unlimited).
module rr_arb_8
    import rr_arb_8_pkg::*;
#(
    parameter int unsigned N         = 8,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*N-1:0] in_data,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [SEL_W-1:0]     sel,
    output logic                 busy,
    output logic                 gnt_new,
    output logic [N-1:0]         out_data
);

    localparam logic [CNT_W-1:0] BurstLim = CNT_W'(MAX_BURST);
    localparam bit               BurstEn  = (MAX_BURST != 0);

    arb_state_e         state_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [SEL_W-1:0]   sel_q;
    logic               busy_q;
    logic               gnt_new_q;
    logic [SEL_W-1:0]   ptr_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [NUM_REQ-1:0] cand;
    logic [SEL_W-1:0]   sel_inc;
    logic [SEL_W-1:0]   pick_start;
    logic [SEL_W:0]     pick_res;
    logic               pick_vld;
    logic [SEL_W-1:0]   pick_idx;
    logic               burst_done;
    logic               rel_grant;
    logic [CNT_W-1:0]   cnt_inc;
    logic [N-1:0]       mux_data;

    // First set bit of cand at or after start, ascending with wrap 7->0.
    // Returns {found, index}.
    function automatic logic [SEL_W:0] pick_rr(input logic [NUM_REQ-1:0] vec,
                                               input logic [SEL_W-1:0]   start);
        logic [SEL_W:0]   res;
        logic [SEL_W-1:0] idx;
        res = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = start + SEL_W'(i);
            if (vec[idx] && !res[SEL_W]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign sel_inc = sel_q + SEL_W'(1);

    // Candidate vector and pick; during a grant the current owner is masked off and the
    // search starts just past it, which is where ptr lands on release.
    always_comb begin
        cand       = req;
        pick_start = ptr_q;
        if (state_q == ST_GRANT) begin
            cand[sel_q] = 1'b0;
            pick_start  = sel_inc;
        end
        pick_res = pick_rr(cand, pick_start);
        pick_vld = pick_res[SEL_W];
        pick_idx = pick_res[SEL_W-1:0];
    end

    // Release and saturating hold counter.
    always_comb begin
        burst_done = BurstEn && (cnt_q == BurstLim);
        rel_grant  = !req[sel_q] || burst_done;
        cnt_inc    = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    end

    // Arbiter FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            sel_q     <= '0;
            busy_q    <= 1'b0;
            gnt_new_q <= 1'b0;
            ptr_q     <= '0;
            cnt_q     <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (pick_vld) begin
                        state_q   <= ST_GRANT;
                        gnt_q     <= onehot(pick_idx);
                        sel_q     <= pick_idx;
                        busy_q    <= 1'b1;
                        gnt_new_q <= 1'b1;
                        cnt_q     <= CNT_W'(1);
                    end else begin
                        gnt_new_q <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    if (!rel_grant) begin
                        cnt_q     <= cnt_inc;
                        gnt_new_q <= 1'b0;
                    end else begin
                        ptr_q <= sel_inc;
                        if (pick_vld) begin
                            // Hand over with no idle bubble.
                            gnt_q     <= onehot(pick_idx);
                            sel_q     <= pick_idx;
                            gnt_new_q <= 1'b1;
                            cnt_q     <= CNT_W'(1);
                        end else if (req[sel_q]) begin
                            // Burst expired but nobody else wants it: start a fresh grant.
                            gnt_new_q <= 1'b1;
                            cnt_q     <= CNT_W'(1);
                        end else begin
                            // sel keeps its last value while idle.
                            state_q   <= ST_IDLE;
                            gnt_q     <= '0;
                            busy_q    <= 1'b0;
                            gnt_new_q <= 1'b0;
                            cnt_q     <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    mux_8 #(
        .N (N)
    ) u_mux (
        .data_i (in_data),
        .sel_i  (sel_q),
        .data_o (mux_data)
    );

    assign gnt      = gnt_q;
    assign sel      = sel_q;
    assign busy     = busy_q;
    assign gnt_new  = gnt_new_q;
    // Gated so an idle datapath reads as zero.
    assign out_data = busy_q ? mux_data : '0;

endmodule

// File: tb/tb_rr_arb_8.sv
// Self-checking bench for rr_arb_8: four instances with different burst limits share the
// stimulus; a behavioural model pushes expected outputs that are popped after each edge.
module tb_rr_arb_8;

    localparam int unsigned N = 8;

    logic           clk;
    logic           rst;
    logic [7:0]     req;
    logic [8*N-1:0] in_data;

    logic [7:0]   gnt_w     [4];
    logic [2:0]   sel_w     [4];
    logic         busy_w    [4];
    logic         gnt_new_w [4];
    logic [N-1:0] data_w    [4];

    logic [1:0] act;
    int         burst_tab [4] = '{8, 2, 3, 0};

    int n_vec;
    int n_err;

    typedef struct packed {
        logic [7:0]   gnt;
        logic [2:0]   sel;
        logic         busy;
        logic         gnt_new;
        logic [N-1:0] data;
    } exp_t;

    exp_t sb_q[$];

    // Model state.
    int m_busy;
    int m_sel;
    int m_ptr;
    int m_age;
    int m_new;

    rr_arb_8 #(.N(N), .MAX_BURST(8)) u_dut_b8 (
        .clk(clk), .rst(rst), .req(req), .in_data(in_data), .gnt(gnt_w[0]), .sel(sel_w[0]),
        .busy(busy_w[0]), .gnt_new(gnt_new_w[0]), .out_data(data_w[0])
    );
    rr_arb_8 #(.N(N), .MAX_BURST(2)) u_dut_b2 (
        .clk(clk), .rst(rst), .req(req), .in_data(in_data), .gnt(gnt_w[1]), .sel(sel_w[1]),
        .busy(busy_w[1]), .gnt_new(gnt_new_w[1]), .out_data(data_w[1])
    );
    rr_arb_8 #(.N(N), .MAX_BURST(3)) u_dut_b3 (
        .clk(clk), .rst(rst), .req(req), .in_data(in_data), .gnt(gnt_w[2]), .sel(sel_w[2]),
        .busy(busy_w[2]), .gnt_new(gnt_new_w[2]), .out_data(data_w[2])
    );
    rr_arb_8 #(.N(N), .MAX_BURST(0)) u_dut_b0 (
        .clk(clk), .rst(rst), .req(req), .in_data(in_data), .gnt(gnt_w[3]), .sel(sel_w[3]),
        .busy(busy_w[3]), .gnt_new(gnt_new_w[3]), .out_data(data_w[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] req_data(input int k);
        return N'(8'h11 * (k + 1));
    endfunction

    // Advance the model across one rising edge with the given rst/req.
    task automatic model_edge(input logic rst_v, input logic [7:0] r);
        int burst;
        int nxt;
        int j;
        bit rel;
        burst = burst_tab[act];
        nxt   = -1;
        if (rst_v) begin
            m_busy = 0; m_sel = 0; m_ptr = 0; m_age = 0; m_new = 0;
            return;
        end
        if (m_busy != 0) begin
            rel = (r[m_sel] == 1'b0) || (burst != 0 && m_age >= burst);
            if (!rel) begin
                m_age = (m_age < 255) ? m_age + 1 : 255;
                m_new = 0;
                return;
            end
            m_ptr = (m_sel + 1) % 8;
            for (int i = 0; i < 8; i++) begin
                j = (m_ptr + i) % 8;
                if (j != m_sel && r[j] && nxt < 0) nxt = j;
            end
            if (nxt < 0 && r[m_sel]) nxt = m_sel;
        end else begin
            for (int i = 0; i < 8; i++) begin
                j = (m_ptr + i) % 8;
                if (r[j] && nxt < 0) nxt = j;
            end
        end
        if (nxt >= 0) begin
            m_busy = 1; m_sel = nxt; m_age = 1; m_new = 1;
        end else begin
            m_busy = 0; m_new = 0;
        end
    endtask

    // One clock: drive on the falling edge, predict, then compare 1 time unit after the edge.
    task automatic cycle(input logic rst_v, input logic [7:0] r);
        exp_t e;
        exp_t got;
        @(negedge clk);
        rst = rst_v;
        req = r;
        model_edge(rst_v, r);
        e.busy    = (m_busy != 0);
        e.sel     = 3'(m_sel);
        e.gnt     = e.busy ? (8'h01 << m_sel) : 8'h00;
        e.gnt_new = (m_new != 0);
        e.data    = e.busy ? req_data(m_sel) : '0;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        check_val("gnt", {24'h0, gnt_w[act]}, {24'h0, got.gnt});
        check_val("sel", {29'h0, sel_w[act]}, {29'h0, got.sel});
        check_val("busy", {31'h0, busy_w[act]}, {31'h0, got.busy});
        check_val("gnt_new", {31'h0, gnt_new_w[act]}, {31'h0, got.gnt_new});
        check_val("out_data", {24'h0, data_w[act]}, {24'h0, got.data});
    endtask

    initial begin
        int pulses;
        int idle_cyc;
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        req   = 8'h00;
        act   = 2'd0;
        for (int k = 0; k < 8; k++) in_data[k*N +: N] = req_data(k);

        // Reset with every request high, then release with no requests.
        cycle(1'b1, 8'hFF);
        cycle(1'b1, 8'hFF);
        check_val("rst_busy", {31'h0, busy_w[0]}, 32'd0);
        cycle(1'b0, 8'h00);
        cycle(1'b0, 8'h00);

        // Single request, dropped after 3 granted cycles.
        cycle(1'b0, 8'h04);
        check_val("single_gnt", {24'h0, gnt_w[0]}, 32'h04);
        check_val("single_sel", {29'h0, sel_w[0]}, 32'd2);
        check_val("single_new", {31'h0, gnt_new_w[0]}, 32'd1);
        cycle(1'b0, 8'h04);
        cycle(1'b0, 8'h04);
        cycle(1'b0, 8'h00);
        check_val("single_drop", {31'h0, busy_w[0]}, 32'd0);
        cycle(1'b0, 8'h00);

        // Simultaneous requests after ptr moved past 2, late higher-priority arrival,
        // and an 8-cycle burst expiry.
        cycle(1'b0, 8'h41);
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'h49);
        for (int i = 0; i < 12; i++) cycle(1'b0, 8'h04);
        cycle(1'b0, 8'h00);

        // Back-to-back round robin with a 2-cycle burst.
        act = 2'd1;
        cycle(1'b1, 8'h00);
        idle_cyc = 0;
        pulses   = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 8'h81);
            if (!busy_w[1]) idle_cyc++;
            if (gnt_new_w[1]) pulses++;
        end
        check_val("rr_no_idle", idle_cyc, 32'd0);
        check_val("rr_switches", pulses, 32'd4);

        // Grant 7 released, pointer wraps: 0 then 1.
        cycle(1'b1, 8'h00);
        cycle(1'b0, 8'h80);
        cycle(1'b0, 8'h80);
        cycle(1'b0, 8'h03);
        check_val("wrap_sel0", {29'h0, sel_w[1]}, 32'd0);
        cycle(1'b0, 8'h03);
        cycle(1'b0, 8'h03);
        check_val("wrap_sel1", {29'h0, sel_w[1]}, 32'd1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h03);

        // Sole requester with a 3-cycle burst keeps being re-granted.
        act = 2'd2;
        cycle(1'b1, 8'h00);
        idle_cyc = 0;
        pulses   = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 8'h10);
            if (!busy_w[2]) idle_cyc++;
            if (gnt_new_w[2]) pulses++;
        end
        check_val("sole_no_idle", idle_cyc, 32'd0);
        check_val("sole_pulses", pulses, 32'd4);

        // Unlimited hold, then reset in the middle of the grant.
        act = 2'd3;
        cycle(1'b1, 8'h00);
        for (int i = 0; i < 310; i++) cycle(1'b0, 8'h22);
        check_val("hold_sel", {29'h0, sel_w[3]}, 32'd1);
        check_val("hold_busy", {31'h0, busy_w[3]}, 32'd1);
        cycle(1'b1, 8'h22);
        check_val("midrst_gnt", {24'h0, gnt_w[3]}, 32'h00);
        cycle(1'b0, 8'h22);
        check_val("after_rst_sel", {29'h0, sel_w[3]}, 32'd1);
        cycle(1'b0, 8'h22);
        cycle(1'b0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
